// File: rtl/datapath_ctrl_pkg.sv
// Shared encodings for the datapath controller: state codes, instruction fields,
// register-select and write-source encodings, and the decoded control word.
package datapath_ctrl_pkg;

  localparam int NSEL_W = 3;

  typedef logic [3:0] state_t;

  localparam state_t S_WAIT     = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_WR_IMM   = 4'd2;
  localparam state_t S_GET_A    = 4'd3;
  localparam state_t S_GET_B    = 4'd4;
  localparam state_t S_EXEC     = 4'd5;
  // EXEC for MOV reg gets its own code so asel stays a pure function of state
  localparam state_t S_EXEC_MOV = 4'd6;
  localparam state_t S_CMP_ST   = 4'd7;
  localparam state_t S_WR_REG   = 4'd8;
  localparam state_t S_HALT     = 4'd9;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_CMP    = 2'b01;
  localparam logic [1:0] OP_AND    = 2'b10;
  localparam logic [1:0] OP_MVN    = 2'b11;
  localparam logic [1:0] OP_MOVIMM = 2'b10;
  localparam logic [1:0] OP_MOVREG = 2'b00;

  localparam logic [NSEL_W-1:0] NSEL_RN = 3'b100;
  localparam logic [NSEL_W-1:0] NSEL_RD = 3'b010;
  localparam logic [NSEL_W-1:0] NSEL_RM = 3'b001;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  typedef struct packed {
    logic              w;
    logic [NSEL_W-1:0] nsel;
    logic [1:0]        vsel;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic              write;
    logic              err;
  } ctrl_out_t;

endpackage

// File: rtl/datapath_controller_if.sv
// Instruction-in / datapath-control-out bundle between decoder, controller and datapath.
interface datapath_controller_if;
  import datapath_ctrl_pkg::*;

  logic              s;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic              w;
  logic [NSEL_W-1:0] nsel;
  logic [1:0]        vsel;
  logic              loada, loadb, loadc, loads;
  logic              asel, bsel;
  logic              write;
  logic              err;

  modport master (
    input  s, opcode, op,
    output w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, err
  );

  modport slave (
    output s, opcode, op,
    input  w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, err
  );
endinterface

// File: rtl/datapath_ctrl_outdec.sv
// Moore output decode: state code in, full datapath control word out.
// DATAPATH_CTRL_ILLEGAL_TRAP_EN adds the HALT decode (err=1); otherwise err is tied 0.
module datapath_ctrl_outdec
  import datapath_ctrl_pkg::*;
(
  input  state_t    state,
  output ctrl_out_t ctl
);
  always_comb begin
    ctl = '0;
    case (state)
      S_WAIT:     ctl.w = 1'b1;
      S_WR_IMM: begin
        ctl.nsel  = NSEL_RN;
        ctl.vsel  = VSEL_IMM8;
        ctl.write = 1'b1;
      end
      S_GET_A: begin
        ctl.nsel  = NSEL_RN;
        ctl.loada = 1'b1;
      end
      S_GET_B: begin
        ctl.nsel  = NSEL_RM;
        ctl.loadb = 1'b1;
      end
      S_EXEC:     ctl.loadc = 1'b1;
      S_EXEC_MOV: begin
        ctl.loadc = 1'b1;
        ctl.asel  = 1'b1;
      end
      S_CMP_ST:   ctl.loads = 1'b1;
      S_WR_REG: begin
        ctl.nsel  = NSEL_RD;
        ctl.vsel  = VSEL_C;
        ctl.write = 1'b1;
      end
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
      S_HALT:     ctl.err = 1'b1;
`endif
      default:    ctl = '0;
    endcase
  end
endmodule

// File: rtl/vDFF.sv
// Plain n-bit rising-edge flop shared across the codebase; reset is muxed in by the user.
module vDFF #(
  parameter int n = 1
) (
  input  logic         clk,
  input  logic [n-1:0] D,
  output logic [n-1:0] Q
);
  always_ff @(posedge clk) Q <= D;
endmodule

// File: rtl/datapath_controller.sv
// Moore sequencer for one decoded MOV/ALU instruction at a time.
// DATAPATH_CTRL_ILLEGAL_TRAP_EN: illegal codes trap into HALT until reset.
module datapath_controller
  import datapath_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  datapath_controller_if.master  bus
);

`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_HALT;
`else
  localparam state_t ILLEGAL_NEXT = S_WAIT;
`endif

  state_t    state, state_next, state_d;
  ctrl_out_t ctl;

  logic is_mov, is_alu;
  assign is_mov = (bus.opcode == OPC_MOV);
  assign is_alu = (bus.opcode == OPC_ALU);

  // state register: reset mux in front of the shared flop
  assign state_d = reset ? S_WAIT : state_next;

  vDFF #(.n(4)) u_state (
    .clk (clk),
    .D   (state_d),
    .Q   (state)
  );

  always_comb begin
    state_next = S_WAIT;
    case (state)
      S_WAIT:   state_next = bus.s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (is_mov && bus.op == OP_MOVIMM)
          state_next = S_WR_IMM;
        else if ((is_mov && bus.op == OP_MOVREG) || (is_alu && bus.op == OP_MVN))
          state_next = S_GET_B;
        else if (is_alu)
          state_next = S_GET_A;
        else
          state_next = ILLEGAL_NEXT;
      end
      S_WR_IMM: state_next = S_WAIT;
      S_GET_A:  state_next = S_GET_B;
      S_GET_B: begin
        if (is_alu && bus.op == OP_CMP) state_next = S_CMP_ST;
        else if (is_mov)                state_next = S_EXEC_MOV;
        else                            state_next = S_EXEC;
      end
      S_EXEC, S_EXEC_MOV: state_next = S_WR_REG;
      S_CMP_ST, S_WR_REG: state_next = S_WAIT;
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
      S_HALT:   state_next = S_HALT;
`endif
      default:  state_next = S_WAIT;
    endcase
  end

  datapath_ctrl_outdec u_outdec (
    .state (state),
    .ctl   (ctl)
  );

  assign bus.w     = ctl.w;
  assign bus.nsel  = ctl.nsel;
  assign bus.vsel  = ctl.vsel;
  assign bus.loada = ctl.loada;
  assign bus.loadb = ctl.loadb;
  assign bus.loadc = ctl.loadc;
  assign bus.loads = ctl.loads;
  assign bus.asel  = ctl.asel;
  assign bus.bsel  = ctl.bsel;
  assign bus.write = ctl.write;
  assign bus.err   = ctl.err;

endmodule

// File: tb/tb_datapath_controller.sv
// Bench: controller driving a small behavioural register-file/ALU datapath; per-instruction
// control traces and register results are predicted from the instruction semantics.
module tb_datapath_controller;
  import datapath_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  datapath_controller_if bus ();

  datapath_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // attached datapath
  logic [2:0]  rn, rd, rm, widx;
  logic [7:0]  imm8;
  logic [15:0] rf [8];
  logic [15:0] ra, rb, rc, ain, bin, alu;
  logic        z;
  int          n_writes = 0;
  int          n_loads  = 0;

  always_comb begin
    case (bus.nsel)
      3'b100:  widx = rn;
      3'b010:  widx = rd;
      3'b001:  widx = rm;
      default: widx = 3'd0;
    endcase
    ain = bus.asel ? 16'd0 : ra;
    bin = bus.bsel ? 16'd0 : rb;
    case (bus.op)
      2'b00:   alu = ain + bin;
      2'b01:   alu = ain - bin;
      2'b10:   alu = ain & bin;
      default: alu = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (bus.write === 1'b1) begin
      rf[widx] <= (bus.vsel == 2'b10) ? {{8{imm8[7]}}, imm8} : rc;
      n_writes <= n_writes + 1;
    end
    if (bus.loada === 1'b1) ra <= rf[widx];
    if (bus.loadb === 1'b1) rb <= rf[widx];
    if (bus.loadc === 1'b1) rc <= alu;
    if (bus.loads === 1'b1) begin
      z       <= (alu == 16'd0);
      n_loads <= n_loads + 1;
    end
  end

  // Expected per-state control words {w,nsel,vsel,loada,loadb,loadc,loads,asel,bsel,write,err}
  localparam logic [13:0] V_WAIT  = {1'b1, 3'b000, 2'b00, 8'b0000_0000};
  localparam logic [13:0] V_IDLE  = {1'b0, 3'b000, 2'b00, 8'b0000_0000};
  localparam logic [13:0] V_WRIMM = {1'b0, 3'b100, 2'b10, 8'b0000_0010};
  localparam logic [13:0] V_GETA  = {1'b0, 3'b100, 2'b00, 8'b1000_0000};
  localparam logic [13:0] V_GETB  = {1'b0, 3'b001, 2'b00, 8'b0100_0000};
  localparam logic [13:0] V_EXEC  = {1'b0, 3'b000, 2'b00, 8'b0010_0000};
  localparam logic [13:0] V_EXECM = {1'b0, 3'b000, 2'b00, 8'b0010_1000};
  localparam logic [13:0] V_CMPS  = {1'b0, 3'b000, 2'b00, 8'b0001_0000};
  localparam logic [13:0] V_WRREG = {1'b0, 3'b010, 2'b00, 8'b0000_0010};
  localparam logic [13:0] V_HALT  = {1'b0, 3'b000, 2'b00, 8'b0000_0001};

  logic [13:0] exp_q [$];
  logic [13:0] obs_q [$];

  function automatic logic [13:0] outs();
    return {bus.w, bus.nsel, bus.vsel, bus.loada, bus.loadb, bus.loadc, bus.loads,
            bus.asel, bus.bsel, bus.write, bus.err};
  endfunction

  // Control trace from the s edge through the return to WAIT, by instruction class
  function automatic void build_trace(input logic [2:0] opc, input logic [1:0] o);
    exp_q.delete();
    exp_q.push_back(V_IDLE);
    if (opc == 3'b110 && o == 2'b10) exp_q.push_back(V_WRIMM);
    else if (opc == 3'b110 && o == 2'b00) begin
      exp_q.push_back(V_GETB); exp_q.push_back(V_EXECM); exp_q.push_back(V_WRREG);
    end else if (opc == 3'b101 && o == 2'b11) begin
      exp_q.push_back(V_GETB); exp_q.push_back(V_EXEC); exp_q.push_back(V_WRREG);
    end else if (opc == 3'b101 && o == 2'b01) begin
      exp_q.push_back(V_GETA); exp_q.push_back(V_GETB); exp_q.push_back(V_CMPS);
    end else if (opc == 3'b101) begin
      exp_q.push_back(V_GETA); exp_q.push_back(V_GETB); exp_q.push_back(V_EXEC);
      exp_q.push_back(V_WRREG);
    end
    exp_q.push_back(V_WAIT);
  endfunction

  function automatic int first_diff();
    if (obs_q.size() != exp_q.size()) return -2;
    foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // noise: 0 s low mid-op, 1 random s mid-op, 2 s high mid-op
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input int noise);
    obs_q.delete();
    bus.opcode = opc;
    bus.op     = o;
    bus.s      = 1'b1;
    @(posedge clk); #1;
    bus.s = 1'b0;
    for (int k = 0; k < 10; k++) begin
      obs_q.push_back(outs());
      if (bus.w === 1'b1) break;
      if (noise == 1) bus.s = 1'($urandom % 2);
      if (noise == 2) bus.s = 1'b1;
      @(posedge clk); #1;
      bus.s = 1'b0;
    end
  endtask

  task automatic load_imm(input logic [2:0] r, input logic [7:0] v);
    int d;
    rn = r; imm8 = v;
    run_instr(3'b110, 2'b10, 0);
    build_trace(3'b110, 2'b10);
    d = first_diff();
    n_checks++;
    if (d != -1) $display("FAIL trace_movimm r%0d idx=%0d got_len=%0d need_len=%0d", r, d, obs_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (rf[r] !== {{8{v[7]}}, v}) $display("FAIL movimm_val r%0d got=%h need=%h", r, rf[r], {{8{v[7]}}, v});
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.s = 1'b0; bus.opcode = 3'b000; bus.op = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++;
    if (outs() !== V_WAIT) $display("FAIL reset_state got=%b need=%b", outs(), V_WAIT);
    else n_pass++;
    // reset wins over s
    reset = 1'b1; bus.s = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.s = 1'b0;
    n_checks++;
    if (outs() !== V_WAIT) $display("FAIL reset_over_s got=%b need=%b", outs(), V_WAIT);
    else n_pass++;
  endtask

  task automatic test_mov_imm();
    for (int r = 0; r < 8; r++) load_imm(3'(r), 8'($urandom));
    load_imm(3'd5, 8'h80);
  endtask

  task automatic test_alu_fixed();
    int d, w0, l0;
    load_imm(3'd1, 8'd3);
    load_imm(3'd2, 8'd4);
    rn = 3'd1; rm = 3'd2; rd = 3'd3;
    l0 = n_loads;
    run_instr(3'b101, 2'b00, 0);
    build_trace(3'b101, 2'b00);
    d = first_diff();
    n_checks++;
    if (d != -1) $display("FAIL trace_add idx=%0d got_len=%0d need_len=%0d", d, obs_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (rf[3] !== 16'd7 || n_loads != l0) $display("FAIL add_result r3=%0d loads=%0d need r3=7 loads=0", rf[3], n_loads - l0);
    else n_pass++;

    load_imm(3'd1, 8'd5);
    load_imm(3'd2, 8'd5);
    w0 = n_writes; l0 = n_loads;
    run_instr(3'b101, 2'b01, 0);
    build_trace(3'b101, 2'b01);
    d = first_diff();
    n_checks++;
    if (d != -1) $display("FAIL trace_cmp idx=%0d got_len=%0d need_len=%0d", d, obs_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (z !== 1'b1 || n_writes != w0 || n_loads != l0 + 1)
      $display("FAIL cmp_result z=%b writes=%0d loads=%0d need z=1 writes=0 loads=1", z, n_writes - w0, n_loads - l0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      logic [2:0]  opc;
      logic [1:0]  o;
      logic [15:0] snap [8];
      logic [15:0] need, got;
      int          d, w0;
      case ($urandom % 6)
        0:       begin opc = 3'b110; o = 2'b10; end
        1:       begin opc = 3'b110; o = 2'b00; end
        2:       begin opc = 3'b101; o = 2'b00; end
        3:       begin opc = 3'b101; o = 2'b01; end
        4:       begin opc = 3'b101; o = 2'b10; end
        default: begin opc = 3'b101; o = 2'b11; end
      endcase
      rn = 3'($urandom); rd = 3'($urandom); rm = 3'($urandom); imm8 = 8'($urandom);
      if (it % 4 == 0) rm = rn;
      snap = rf;
      w0 = n_writes;
      run_instr(opc, o, (it % 3 == 2) ? 2 : 1);
      build_trace(opc, o);
      d = first_diff();
      n_checks++;
      if (d != -1) $display("FAIL trace_rand it=%0d opc=%b op=%b idx=%0d got_len=%0d need_len=%0d",
                            it, opc, o, d, obs_q.size(), exp_q.size());
      else n_pass++;
      if (opc == 3'b101 && o == 2'b01) begin
        n_checks++;
        if (z !== (snap[rn] == snap[rm]) || n_writes != w0)
          $display("FAIL cmp_rand it=%0d z=%b writes=%0d need z=%b writes=0", it, z, n_writes - w0, snap[rn] == snap[rm]);
        else n_pass++;
      end else begin
        if (opc == 3'b110 && o == 2'b10) begin need = {{8{imm8[7]}}, imm8}; got = rf[rn]; end
        else begin
          got = rf[rd];
          if (opc == 3'b110)   need = snap[rm];
          else if (o == 2'b00) need = snap[rn] + snap[rm];
          else if (o == 2'b10) need = snap[rn] & snap[rm];
          else                 need = ~snap[rm];
        end
        n_checks++;
        if (got !== need) $display("FAIL result_rand it=%0d opc=%b op=%b got=%h need=%h", it, opc, o, got, need);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    rn = 3'd0; imm8 = 8'h5a;
    bus.opcode = 3'b110; bus.op = 2'b10; bus.s = 1'b1;
    w0 = n_writes;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.w !== (k % 3 == 0)) $display("FAIL b2b_w edge=%0d got=%b need=%b", k, bus.w, k % 3 == 0);
      else n_pass++;
    end
    bus.s = 1'b0;
    n_checks++;
    if (n_writes - w0 != 3) $display("FAIL b2b_writes got=%0d need=3", n_writes - w0);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    int w0;
    load_imm(3'd3, 8'h11);
    rn = 3'd1; rm = 3'd2; rd = 3'd3;
    bus.opcode = 3'b101; bus.op = 2'b00; bus.s = 1'b1;
    @(posedge clk); #1 bus.s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (outs() !== V_GETB) $display("FAIL midop_getb got=%b need=%b", outs(), V_GETB);
    else n_pass++;
    w0 = n_writes;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (outs() !== V_WAIT) $display("FAIL midop_wait cyc=%0d got=%b need=%b", k, outs(), V_WAIT);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (rf[3] !== 16'h0011 || n_writes != w0)
      $display("FAIL midop_nowrite r3=%h writes=%0d need r3=0011 writes=0", rf[3], n_writes - w0);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [2:0] opc_l [2];
    logic [1:0] op_l [2];
    int w0;
    opc_l[0] = 3'b000; op_l[0] = 2'($urandom);
    opc_l[1] = 3'b110; op_l[1] = ($urandom % 2 == 0) ? 2'b01 : 2'b11;
    for (int t = 0; t < 2; t++) begin
      w0 = n_writes;
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
      bus.opcode = opc_l[t]; bus.op = op_l[t]; bus.s = 1'b1;
      @(posedge clk); #1 bus.s = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        n_checks++;
        if (outs() !== V_HALT) $display("FAIL halt_hold t=%0d cyc=%0d got=%b need=%b", t, k, outs(), V_HALT);
        else n_pass++;
        bus.s = 1'($urandom % 2);
      end
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; bus.s = 1'b0;
      n_checks++;
      if (outs() !== V_WAIT) $display("FAIL halt_exit t=%0d got=%b need=%b", t, outs(), V_WAIT);
      else n_pass++;
`else
      run_instr(opc_l[t], op_l[t], 1);
      exp_q.delete();
      exp_q.push_back(V_IDLE);
      exp_q.push_back(V_WAIT);
      n_checks++;
      if (first_diff() != -1) $display("FAIL illegal_trace t=%0d got_len=%0d need_len=2", t, obs_q.size());
      else n_pass++;
`endif
      n_checks++;
      if (n_writes != w0) $display("FAIL illegal_nowrite t=%0d writes=%0d need=0", t, n_writes - w0);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.s = 1'b0; bus.opcode = 3'b000; bus.op = 2'b00;
    rn = 3'd0; rd = 3'd0; rm = 3'd0; imm8 = 8'd0;
    test_reset();
    test_mov_imm();
    test_alu_fixed();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
Moore FSM that sequences the register-file/ALU datapath for one decoded instruction at a time. It takes the opcode and op fields plus a start strobe and drives all datapath load enables, mux selects and the register-file write strobe. It also drives a one-hot register-select vector that an external mux turns into readnum/writenum (Rn/Rd/Rm). It sits between the instruction register/decoder and the datapath.

Parameters:
- NSEL_W, 3, width of the one-hot register-select vector (bit2=Rn, bit1=Rd, bit0=Rm); fixed at 3

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; forces state to WAIT on the next clk edge
- s  in  1  start strobe; sampled only in WAIT
- opcode  in  3  instruction opcode; 3'b110 = MOV, 3'b101 = ALU
- op  in  2  sub-op; for MOV, 10 = imm and 00 = reg; for ALU, 00 = ADD, 01 = CMP, 10 = AND, 11 = MVN
- w  out  1  high only in WAIT, meaning ready
- nsel  out  3  one-hot register select; 000 when no register is addressed
- vsel  out  2  register-file write source; 00 = C, 01 = PC, 10 = sximm8, 11 = mdata
- loada, loadb, loadc, loads  out  1 each  datapath register enables
- asel, bsel  out  1 each  datapath operand selects
- write  out  1  register-file write strobe
- err  out  1  illegal-instruction flag (see Optional Feature)

Behaviour:
- Outputs are a pure Moore decode of the state register. There is no combinational path from s, opcode or op to any output.
- opcode and op must be held stable from the s cycle until w returns high. They are sampled combinationally in DECODE and GET_B.
- States and the outputs each one asserts (any output not listed is 0):
  - WAIT: w=1. Goes to DECODE when s=1, else stays in WAIT.
  - DECODE: no outputs. Transitions:
    - MOV imm (110/10) goes to WR_IMM.
    - MOV reg (110/00) or MVN (101/11) goes to GET_B.
    - ADD, CMP or AND (101/00, 01, 10) goes to GET_A.
    - Any other opcode/op goes to WAIT (ILLEGAL_TRAP_EN changes this).
  - WR_IMM: nsel=100, vsel=10, write=1. Goes to WAIT.
  - GET_A: nsel=100, loada=1. Goes to GET_B.
  - GET_B: nsel=001, loadb=1. Goes to CMP_ST if the instruction is CMP, else to EXEC.
  - EXEC: loadc=1, bsel=0. asel=1 for MOV reg, asel=0 otherwise. Goes to WR_REG.
  - CMP_ST: loads=1, asel=0, bsel=0. Goes to WAIT.
  - WR_REG: nsel=010, vsel=00, write=1. Goes to WAIT.
- Latency, counted as clk edges from the edge that samples s=1 to the edge that re-enters WAIT:
  - MOV imm: 2
  - MOV reg and MVN: 4
  - ADD and AND: 5
  - CMP: 4
- Only CMP asserts loads. write is never asserted in the same state as loada, loadb, loadc or loads.
- s outside WAIT is ignored; it is not queued. s held high in WAIT starts back-to-back instructions with no idle cycle beyond WAIT itself.
- Reset:
  - reset=1 at any edge, including mid-instruction, puts the state in WAIT.
  - From the following cycle: w=1, nsel=000, vsel=00, err=0, and all strobes are 0.
  - reset has priority over s.
- vsel=01 (PC) and vsel=11 (mdata) are legal encodings reserved for later memory/branch states. This block never drives them.

Optional Feature:
- Macro: DATAPATH_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported opcode/op in DECODE goes to a HALT state.
  - HALT holds err=1, w=0 and all strobes 0, and ignores s.
  - Only reset leaves HALT.
- Not defined:
  - No HALT state exists. An unsupported code returns to WAIT with no datapath activity.
  - err is tied 0.

Decomposition:
- Shared package datapath_ctrl_pkg holds:
  - state encoding constants (4-bit binary)
  - opcode/op constants (OPC_MOV, OPC_ALU, OP_ADD, OP_CMP, OP_AND, OP_MVN, OP_MOVIMM, OP_MOVREG)
  - NSEL_RN, NSEL_RD, NSEL_RM
  - VSEL_C, VSEL_PC, VSEL_IMM8, VSEL_MDATA
- The state register uses the existing vDFF flop with a reset mux in front; no new flop module.
- One natural sub-module: datapath_ctrl_outdec, the combinational state-to-outputs decode. The top keeps the next-state logic.

Test Plan:
- reset=1 for 1 edge in any state -> w=1, nsel=000, vsel=00, write=0, loada/loadb/loadc/loads=0.
- opcode=110, op=10, s pulse -> DECODE, then WR_IMM with nsel=100, vsel=10, write=1 for exactly 1 cycle, then w=1 at edge 2.
- opcode=101, op=00 (ADD), s pulse, with datapath attached (R1=3, R2=4, Rd=R3) -> loada at edge 2, loadb at edge 3, loadc at edge 4, write with nsel=010 at edge 5 -> R3=7, loads never asserted.
- opcode=101, op=01 (CMP) with R1=R2=5 -> loads=1 for 1 cycle, write never asserted, status Z bit=1, w=1 after 4 edges.
- opcode=110, op=00 (MOV reg) and opcode=101, op=11 (MVN) -> GET_A skipped; asel=1 in EXEC for MOV reg only; 4-edge latency each.
- reset asserted during GET_B of an ADD, and s pulsed during EXEC -> no write occurs, state is WAIT next cycle, the mid-op s has no effect. With opcode=000 under DATAPATH_CTRL_ILLEGAL_TRAP_EN -> err=1 and w=0 held until reset.
